// File: rtl/cw_mem_stage_if.sv
// Memory-side bus of the C->W memory stage: one outstanding request,
// held stable until the memory acknowledges it.
interface cw_mem_stage_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [3:0]            mem_be;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Pipeline stage side: issues requests, consumes acknowledge and read data
  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  // Memory side: receives requests, returns acknowledge and read data
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/cw_mem_stage.sv
// C->W memory stage. Pass-ops flow through in one cycle; aligned byte/word
// accesses stall the C stage while a single memory request is outstanding;
// misaligned word accesses retire immediately with exc_misaligned set.
module cw_mem_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  C_valid,
  input  logic [DATA_WIDTH-1:0] C_w,
  input  logic [DATA_WIDTH-1:0] C_data,
  input  logic [6:0]            C_regDst,
  input  logic [1:0]            C_DC_rd_wr,
  input  logic                  C_DC_we,
  input  logic                  C_MuxD,
  input  logic                  C_RF_wrd,
  output logic                  stall,
  cw_mem_stage_if.master        mem,
  output logic                  W_valid,
  output logic [DATA_WIDTH-1:0] W_w,
  output logic [6:0]            W_regDst,
  output logic                  W_RF_wrd,
  output logic                  exc_misaligned
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Byte-enable pattern for the access size and byte offset
  function automatic logic [3:0] calc_be(input logic is_byte, input logic [1:0] ofs);
    logic [3:0] be;
    if (is_byte) begin
      be = 4'b0001 << ofs;
    end else begin
      be = 4'b1111;
    end
    return be;
  endfunction

  // Write data lane formatting: bytes are replicated into every lane
  function automatic logic [DATA_WIDTH-1:0] calc_wdata(input logic is_byte,
                                                       input logic [DATA_WIDTH-1:0] data);
    logic [DATA_WIDTH-1:0] wd;
    if (is_byte) begin
      wd = {(DATA_WIDTH/8){data[7:0]}};
    end else begin
      wd = data;
    end
    return wd;
  endfunction

  state_t                state_q;
  logic                  mem_req_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            be_q;
  logic                  we_q;
  logic                  byte_q;
  logic [6:0]            regdst_q;
  logic                  muxd_q;
  logic                  rfwrd_q;
  logic                  W_valid_q;
  logic [DATA_WIDTH-1:0] W_w_q;
  logic [6:0]            W_regDst_q;
  logic                  W_RF_wrd_q;
  logic                  exc_q;

  logic                  is_byte_s;
  logic                  is_word_s;
  logic                  mem_op_s;
  logic                  misaligned_s;
  logic                  issue_s;
  logic [7:0]            lane_s;
  logic [DATA_WIDTH-1:0] load_data_s;
  logic                  stall_s;

  // Decode the C-stage instruction; size code 11 behaves like 00
  always_comb begin
    is_byte_s    = (C_DC_rd_wr == 2'b01);
    is_word_s    = (C_DC_rd_wr == 2'b10);
    mem_op_s     = C_valid & (is_byte_s | is_word_s);
    misaligned_s = mem_op_s & is_word_s & (C_w[1:0] != 2'b00);
    issue_s      = mem_op_s & ~misaligned_s;
  end

  // Select the addressed byte lane of the read word and form load data
  always_comb begin
    lane_s = 8'h00;
    case (addr_q[1:0])
      2'b00:   lane_s = mem.mem_rdata[7:0];
      2'b01:   lane_s = mem.mem_rdata[15:8];
      2'b10:   lane_s = mem.mem_rdata[23:16];
      2'b11:   lane_s = mem.mem_rdata[31:24];
      default: lane_s = 8'h00;
    endcase
    if (byte_q) begin
      load_data_s = {{(DATA_WIDTH-8){1'b0}}, lane_s};
    end else begin
      load_data_s = mem.mem_rdata;
    end
  end

  // Upstream hold: set while accepting or waiting on a memory op, forced low in reset
  always_comb begin
    stall_s = 1'b0;
    case (state_q)
      ST_IDLE: stall_s = issue_s;
      ST_BUSY: stall_s = 1'b1;
      ST_DONE: stall_s = 1'b0;
      default: stall_s = 1'b0;
    endcase
    if (!rst_n) begin
      stall_s = 1'b0;
    end else begin
      stall_s = stall_s;
    end
  end

  // Stage FSM with latched request fields and registered writeback bundle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mem_req_q  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= 4'b0000;
      we_q       <= 1'b0;
      byte_q     <= 1'b0;
      regdst_q   <= 7'd0;
      muxd_q     <= 1'b0;
      rfwrd_q    <= 1'b0;
      W_valid_q  <= 1'b0;
      W_w_q      <= '0;
      W_regDst_q <= 7'd0;
      W_RF_wrd_q <= 1'b0;
      exc_q      <= 1'b0;
    end else begin
      exc_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (issue_s) begin
            addr_q     <= C_w;
            wdata_q    <= calc_wdata(is_byte_s, C_data);
            be_q       <= calc_be(is_byte_s, C_w[1:0]);
            we_q       <= C_DC_we;
            byte_q     <= is_byte_s;
            regdst_q   <= C_regDst;
            muxd_q     <= C_MuxD;
            rfwrd_q    <= C_RF_wrd;
            mem_req_q  <= 1'b1;
            W_valid_q  <= 1'b0;
            W_RF_wrd_q <= 1'b0;
            state_q    <= ST_BUSY;
          end else if (misaligned_s) begin
            W_valid_q  <= 1'b1;
            W_w_q      <= C_w;
            W_regDst_q <= C_regDst;
            W_RF_wrd_q <= 1'b0;
            exc_q      <= 1'b1;
          end else begin
            W_valid_q  <= C_valid;
            W_w_q      <= C_w;
            W_regDst_q <= C_regDst;
            W_RF_wrd_q <= C_RF_wrd & C_valid;
          end
        end
        ST_BUSY: begin
          if (mem.mem_ack) begin
            W_valid_q  <= 1'b1;
            W_regDst_q <= regdst_q;
            W_RF_wrd_q <= rfwrd_q;
            W_w_q      <= muxd_q ? load_data_s : addr_q;
            mem_req_q  <= 1'b0;
            state_q    <= ST_DONE;
          end else begin
            W_valid_q  <= 1'b0;
          end
        end
        ST_DONE: begin
          // C still shows the completed instruction; it is dropped, not re-issued
          W_valid_q  <= 1'b0;
          W_w_q      <= '0;
          W_RF_wrd_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: begin
          W_valid_q  <= 1'b0;
          mem_req_q  <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign stall          = stall_s;
  assign mem.mem_req    = mem_req_q;
  assign mem.mem_we     = mem_req_q & we_q;
  assign mem.mem_addr   = {addr_q[DATA_WIDTH-1:2], 2'b00};
  assign mem.mem_wdata  = wdata_q;
  assign mem.mem_be     = be_q;
  assign W_valid        = W_valid_q;
  assign W_w            = W_w_q;
  assign W_regDst       = W_regDst_q;
  assign W_RF_wrd       = W_RF_wrd_q;
  assign exc_misaligned = exc_q;

endmodule

// File: tb/tb_cw_mem_stage.sv
// Self-checking bench for cw_mem_stage: directed cases, a reset-during-BUSY
// scenario and randomized instructions against a transaction-level model.
module tb_cw_mem_stage;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          c_valid;
  logic [DW-1:0] c_w;
  logic [DW-1:0] c_data;
  logic [6:0]    c_regdst;
  logic [1:0]    c_rd_wr;
  logic          c_we;
  logic          c_muxd;
  logic          c_rf_wrd;
  logic          stall;
  logic          w_valid;
  logic [DW-1:0] w_w;
  logic [6:0]    w_regdst;
  logic          w_rf_wrd;
  logic          exc_mis;

  int err_cnt = 0;
  int chk_cnt = 0;

  cw_mem_stage_if #(.DATA_WIDTH(DW)) mif();

  cw_mem_stage #(.DATA_WIDTH(DW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .C_valid        (c_valid),
    .C_w            (c_w),
    .C_data         (c_data),
    .C_regDst       (c_regdst),
    .C_DC_rd_wr     (c_rd_wr),
    .C_DC_we        (c_we),
    .C_MuxD         (c_muxd),
    .C_RF_wrd       (c_rf_wrd),
    .stall          (stall),
    .mem            (mif),
    .W_valid        (w_valid),
    .W_w            (w_w),
    .W_regDst       (w_regdst),
    .W_RF_wrd       (w_rf_wrd),
    .exc_misaligned (exc_mis)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one instruction (called just after a falling edge) and check it to retirement.
  task automatic run_instr(input logic v, input logic [31:0] w, input logic [31:0] d,
                           input logic [6:0] rd, input logic [1:0] sz, input logic we,
                           input logic mx, input logic rf, input int dly,
                           input logic [31:0] rdata);
    logic        memop;
    logic        mis;
    logic        is_byte;
    int          stalls;
    logic [31:0] exp_w;
    logic [31:0] exp_wd;
    logic [3:0]  exp_be;
    logic [31:0] loaded;
    c_valid  = v;   c_w = w;     c_data = d;   c_regdst = rd;
    c_rd_wr  = sz;  c_we = we;   c_muxd = mx;  c_rf_wrd = rf;
    is_byte  = (sz == 2'b01);
    memop    = v && (sz == 2'b01 || sz == 2'b10);
    mis      = memop && (sz == 2'b10) && (w % 4 != 0);
    if (!memop || mis) begin
      // acknowledge outside BUSY must have no effect
      mif.mem_ack   = 1'($urandom % 2);
      mif.mem_rdata = $urandom;
      #1;
      chk("stall_pass", stall, 0);
      chk("req_pass", mif.mem_req, 0);
      @(negedge clk);
      chk("wvalid_pass", w_valid, mis ? 1 : v);
      chk("ww_pass", w_w, w);
      chk("wrd_pass", w_regdst, rd);
      chk("wrf_pass", w_rf_wrd, mis ? 0 : (rf & v));
      chk("exc_pass", exc_mis, mis);
      mif.mem_ack = 1'b0;
    end else begin
      mif.mem_ack = 1'b0;
      exp_be = is_byte ? 4'(1 << (w % 4)) : 4'hF;
      exp_wd = is_byte ? {4{d[7:0]}} : d;
      #1;
      stalls = int'(stall);
      @(negedge clk);
      for (int k = 1; k <= dly; k++) begin
        chk("req_busy", mif.mem_req, 1);
        chk("addr_busy", mif.mem_addr, w - (w % 4));
        chk("be_busy", mif.mem_be, exp_be);
        chk("wdata_busy", mif.mem_wdata, exp_wd);
        chk("we_busy", mif.mem_we, we);
        chk("wvalid_busy", w_valid, 0);
        stalls += int'(stall);
        if (k == dly) begin
          mif.mem_ack = 1'b1;  mif.mem_rdata = rdata;
        end else begin
          mif.mem_ack = 1'b0;  mif.mem_rdata = $urandom;
        end
        @(negedge clk);
      end
      mif.mem_ack = 1'b0;
      loaded = is_byte ? ((rdata >> (8 * (w % 4))) & 32'hFF) : rdata;
      exp_w  = mx ? loaded : w;
      chk("stall_cnt", 64'(stalls), 64'(dly + 1));
      chk("wvalid_done", w_valid, 1);
      chk("ww_done", w_w, exp_w);
      chk("wrd_done", w_regdst, rd);
      chk("wrf_done", w_rf_wrd, rf);
      chk("exc_done", exc_mis, 0);
      chk("stall_done", stall, 0);
      chk("req_done", mif.mem_req, 0);
      @(negedge clk);
      chk("wvalid_after", w_valid, 0);
      chk("req_after", mif.mem_req, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mif.mem_ack = 1'b0;  mif.mem_rdata = 32'h0;
    // reset with an aligned memory op presented: nothing may react
    c_valid = 1'b1;  c_w = 32'h100;  c_data = 32'h0;  c_regdst = 7'd1;
    c_rd_wr = 2'b10; c_we = 1'b0;    c_muxd = 1'b1;   c_rf_wrd = 1'b1;
    #12;
    chk("rst_stall", stall, 0);
    chk("rst_req", mif.mem_req, 0);
    chk("rst_wvalid", w_valid, 0);
    chk("rst_ww", w_w, 0);
    chk("rst_exc", exc_mis, 0);
    c_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    run_instr(1'b1, 32'h1234, 32'h0, 7'd5, 2'b00, 1'b0, 1'b0, 1'b1, 1, 32'h0);
    run_instr(1'b1, 32'h100, 32'h0, 7'd3, 2'b10, 1'b0, 1'b1, 1'b1, 3, 32'hDEADBEEF);
    run_instr(1'b1, 32'h203, 32'hAB, 7'd9, 2'b01, 1'b1, 1'b0, 1'b0, 2, 32'h0);
    run_instr(1'b1, 32'h201, 32'h0, 7'd4, 2'b01, 1'b0, 1'b1, 1'b1, 1, 32'h11223344);
    run_instr(1'b1, 32'h102, 32'h0, 7'd6, 2'b10, 1'b0, 1'b1, 1'b1, 1, 32'h0);
    run_instr(1'b1, 32'h55, 32'h0, 7'd7, 2'b11, 1'b1, 1'b1, 1'b1, 1, 32'h0);
    run_instr(1'b0, 32'h104, 32'h0, 7'd8, 2'b10, 1'b0, 1'b1, 1'b1, 1, 32'h0);

    // reset while BUSY, then a stray acknowledge after release
    c_valid = 1'b1;  c_w = 32'h300;  c_rd_wr = 2'b10;  c_we = 1'b0;
    c_muxd  = 1'b1;  c_rf_wrd = 1'b1; c_regdst = 7'd10;
    @(negedge clk);
    @(negedge clk);
    chk("rstb_req_pre", mif.mem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("rstb_req", mif.mem_req, 0);
    chk("rstb_stall", stall, 0);
    chk("rstb_wvalid", w_valid, 0);
    c_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mif.mem_ack = 1'b1;  mif.mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    mif.mem_ack = 1'b0;
    chk("rstb_wvalid_ack", w_valid, 0);
    chk("rstb_req_ack", mif.mem_req, 0);
    @(negedge clk);
    chk("rstb_wvalid_idle", w_valid, 0);
    run_instr(1'b1, 32'h4321, 32'h0, 7'd11, 2'b00, 1'b0, 1'b0, 1'b1, 1, 32'h0);

    // randomized instruction stream
    for (int i = 0; i < 150; i++) begin
      run_instr(1'($urandom % 8 != 0), $urandom, $urandom, 7'($urandom),
                2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                int'($urandom_range(1, 4)), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
